// File: rtl/mul_err_pkg.sv
// -----------------------------------------------------------------------------
// mul_err_pkg
// Shared types and width helpers for the approximate-multiplier error
// statistics collector.
//   state_t : collector FSM states (IDLE, RUN, DRAIN, DONE)
//   err_w   : width of a signed (appr - precise) difference
//   sum_w   : width of the signed error accumulator
//   sq_w    : width of the unsigned squared-error accumulator
//   abs_w   : width of the unsigned |precise| accumulator
// -----------------------------------------------------------------------------
package mul_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One extra bit so the difference of two DATA_W words never wraps.
  function automatic int err_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int sum_w(input int data_w, input int cnt_w);
    return err_w(data_w) + cnt_w;
  endfunction

  function automatic int sq_w(input int data_w, input int cnt_w);
    return 2 * data_w + 1 + cnt_w;
  endfunction

  function automatic int abs_w(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction

endpackage

// File: rtl/mul_err_stage.sv
// -----------------------------------------------------------------------------
// mul_err_stage
// First pipeline stage of the collector: registers the signed difference,
// the magnitude of the precise result and the exact-match flag for one
// accepted pair, together with a valid bit.
//   clk, rst_n : clock, synchronous active-low reset (clears vld only)
//   load       : pair accepted this cycle
//   appr       : signed approximate result
//   precise    : signed precise result
//   vld        : err/abs_ref/eq hold a pair not yet accumulated
//   err        : appr - precise, DATA_W+1 bits signed
//   abs_ref    : |precise|, DATA_W bits unsigned
//   eq         : appr == precise
// -----------------------------------------------------------------------------
module mul_err_stage
  import mul_err_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic signed [DATA_W-1:0]        appr,
  input  logic signed [DATA_W-1:0]        precise,
  output logic                            vld,
  output logic signed [err_w(DATA_W)-1:0] err,
  output logic        [DATA_W-1:0]        abs_ref,
  output logic                            eq
);

  always_ff @(posedge clk) begin
    if (!rst_n) vld <= 1'b0;
    else        vld <= load;
  end

  // NOTE: the data registers carry no reset; they are only consumed while
  // vld is high, so clearing them would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (load) begin
      // Sign-extend both operands first so the difference cannot wrap.
      err     <= {appr[DATA_W-1], appr} - {precise[DATA_W-1], precise};
      // Unsigned result: |-2^(DATA_W-1)| = 2^(DATA_W-1) still fits.
      abs_ref <= precise[DATA_W-1] ? (~precise + DATA_W'(1)) : precise;
      eq      <= (appr == precise);
    end
  end

endmodule

// File: rtl/mul_err_stat_collector.sv
// -----------------------------------------------------------------------------
// mul_err_stat_collector
// Error characterisation sink for approximate multipliers. Accepts a
// programmed number of (appr, precise) pairs over valid/ready and
// accumulates error sum, squared-error sum, |precise| sum and the count of
// exact matches.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begin a run (honoured in IDLE/DONE only)
//   num_samples  : pairs per run, captured with start
//   in_valid     : upstream pair valid
//   in_ready     : collector will accept a pair this cycle
//   appr/precise : signed result pair
//   busy         : run in progress (RUN or DRAIN)
//   done         : statistics final and stable
//   sample_cnt   : pairs accepted this run
//   exact_cnt    : pairs with appr == precise
//   err_sum      : signed sum of (appr - precise)
//   err_sq_sum   : sum of (appr - precise)^2
//   ref_abs_sum  : sum of |precise|
// -----------------------------------------------------------------------------
module mul_err_stat_collector
  import mul_err_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic        [CNT_W-1:0]               num_samples,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [DATA_W-1:0]              appr,
  input  logic signed [DATA_W-1:0]              precise,
  output logic                                  busy,
  output logic                                  done,
  output logic        [CNT_W-1:0]               sample_cnt,
  output logic        [CNT_W-1:0]               exact_cnt,
  output logic signed [sum_w(DATA_W, CNT_W)-1:0] err_sum,
  output logic        [sq_w(DATA_W, CNT_W)-1:0]  err_sq_sum,
  output logic        [abs_w(DATA_W, CNT_W)-1:0] ref_abs_sum
);

  localparam int ERR_W = err_w(DATA_W);
  localparam int SUM_W = sum_w(DATA_W, CNT_W);
  localparam int SQ_W  = sq_w(DATA_W, CNT_W);
  localparam int ABS_W = abs_w(DATA_W, CNT_W);

  state_t                    state;
  logic        [CNT_W-1:0]   target;
  logic        [CNT_W-1:0]   accept_cnt;
  logic                      accept;
  logic                      s1_vld;
  logic signed [ERR_W-1:0]   s1_err;
  logic        [DATA_W-1:0]  s1_abs;
  logic                      s1_eq;
  logic                      s2_vld;
  logic signed [2*ERR_W-1:0] err_sq;

  assign in_ready   = (state == RUN) && (accept_cnt < target);
  assign accept     = in_valid && in_ready;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign sample_cnt = accept_cnt;

  mul_err_stage #(.DATA_W(DATA_W)) u_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .appr    (appr),
    .precise (precise),
    .vld     (s1_vld),
    .err     (s1_err),
    .abs_ref (s1_abs),
    .eq      (s1_eq)
  );

  // The only wide multiplier; a square is never negative.
  assign err_sq = s1_err * s1_err;

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      target      <= '0;
      accept_cnt  <= '0;
      s2_vld      <= 1'b0;
      exact_cnt   <= '0;
      err_sum     <= '0;
      err_sq_sum  <= '0;
      ref_abs_sum <= '0;
    end else begin
      // s2_vld marks the edge at which the last S1 entry was folded in;
      // DRAIN waits on it so done follows the final accept by three edges.
      s2_vld <= s1_vld;
      if (s1_vld) begin
        err_sum     <= err_sum + {{(SUM_W-ERR_W){s1_err[ERR_W-1]}}, s1_err};
        err_sq_sum  <= err_sq_sum + {{(SQ_W-2*ERR_W){1'b0}}, err_sq};
        ref_abs_sum <= ref_abs_sum + {{(ABS_W-DATA_W){1'b0}}, s1_abs};
        exact_cnt   <= exact_cnt + {{(CNT_W-1){1'b0}}, s1_eq};
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            target      <= num_samples;
            accept_cnt  <= '0;
            exact_cnt   <= '0;
            err_sum     <= '0;
            err_sq_sum  <= '0;
            ref_abs_sum <= '0;
            state       <= (num_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            accept_cnt <= accept_cnt + CNT_W'(1);
            if (accept_cnt + CNT_W'(1) == target) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_vld && !s2_vld) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_err_stat_collector.sv
// -----------------------------------------------------------------------------
// tb_mul_err_stat_collector
// Directed and randomized bench for mul_err_stat_collector. Inputs change and
// outputs are sampled on the falling clock edge. Expected statistics come
// from plain integer arithmetic over the pairs the bench sends.
// -----------------------------------------------------------------------------
module tb_mul_err_stat_collector;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 20;
  localparam int SUM_W  = DATA_W + 1 + CNT_W;
  localparam int SQ_W   = 2 * DATA_W + 1 + CNT_W;
  localparam int ABS_W  = DATA_W + CNT_W;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic        [CNT_W-1:0]  num_samples;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] appr;
  logic signed [DATA_W-1:0] precise;
  logic                     busy;
  logic                     done;
  logic        [CNT_W-1:0]  sample_cnt;
  logic        [CNT_W-1:0]  exact_cnt;
  logic signed [SUM_W-1:0]  err_sum;
  logic        [SQ_W-1:0]   err_sq_sum;
  logic        [ABS_W-1:0]  ref_abs_sum;

  int n_checks = 0;
  int n_fail   = 0;

  mul_err_stat_collector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .appr        (appr),
    .precise     (precise),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .exact_cnt   (exact_cnt),
    .err_sum     (err_sum),
    .err_sq_sum  (err_sq_sum),
    .ref_abs_sum (ref_abs_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input int n);
    num_samples = CNT_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer one pair and hold it until the handshake completes.
  task automatic push(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] p);
    appr = a;
    precise = p;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0;
    check("push_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50; i++) begin
      if (done) return;
      step();
    end
    check("done_timeout", {127'd0, done}, 128'd1);
  endtask

  task automatic check_stats(input string tag, input longint e_cnt, input longint e_exact,
                             input longint e_err, input logic [127:0] e_sq, input longint e_abs);
    check({tag, "_sample_cnt"},  sample_cnt,  e_cnt);
    check({tag, "_exact_cnt"},   exact_cnt,   e_exact);
    check({tag, "_err_sum"},     err_sum,     e_err);
    check({tag, "_err_sq_sum"},  err_sq_sum,  e_sq);
    check({tag, "_ref_abs_sum"}, ref_abs_sum, e_abs);
  endtask

  // Behavioural stand-in for an approximate 12-bit multiplier: exact
  // product with the low 4 magnitude bits dropped (truncation toward zero).
  function automatic int mul_ex_12bit_model(input int a, input int b);
    int p;
    p = a * b;
    return (p >= 0) ? (p & ~15) : -((-p) & ~15);
  endfunction

  initial begin
    int vpat [6] = '{1, 0, 0, 1, 0, 1};
    int da   [3] = '{1, 3, -4};
    int dp   [3] = '{2, 3, 4};
    int k;
    longint ref_err, ref_sq, ref_abs, ref_exact;
    logic signed [11:0] a12, b12;
    int pa, pp;
    longint e;

    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    appr = '0;
    precise = '0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_stats("rst", 0, 0, 0, 0, 0);

    // Reset in the middle of a run discards it
    do_start(5);
    push(32'sd100, 32'sd90);
    push(-32'sd7, 32'sd7);
    step();
    step();
    check("midrun_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrun_rst_in_ready", in_ready, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check_stats("midrun_rst", 0, 0, 0, 0, 0);

    // Four back-to-back pairs, with done latency
    do_start(4);
    check("run4_busy", busy, 1);
    push(32'sd10, 32'sd10);
    push(32'sd12, 32'sd10);
    push(-32'sd5, -32'sd3);
    push(32'sd7, 32'sd7);
    check("run4_done_e0", done, 0);
    step();
    step();
    check("run4_done_e2", done, 0);
    step();
    check("run4_done_e3", done, 1);
    check("run4_busy_done", busy, 0);
    check_stats("run4", 4, 2, 0, 8, 30);

    // Extreme operands
    do_start(1);
    push(32'sh7FFFFFFF, 32'sh80000000);
    wait_done();
    check_stats("extreme", 1, 0, 64'd4294967295, 128'd18446744065119617025, 64'd2147483648);

    // Valid toggling with bubbles, then extra valid after target
    do_start(3);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      check("toggle_in_ready", in_ready, 1);
      if (vpat[i] != 0) begin
        appr = da[k];
        precise = dp[k];
        k++;
      end
      in_valid = (vpat[i] != 0);
      step();
    end
    check("toggle_cnt_at_target", sample_cnt, 3);
    appr = 32'sd99;
    precise = 32'sd1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("toggle_extra_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    wait_done();
    check_stats("toggle", 3, 1, -9, 65, 9);

    // Zero-sample run finishes immediately with cleared sums
    do_start(0);
    check("zero_done_next", done, 1);
    check("zero_busy", busy, 0);
    check_stats("zero", 0, 0, 0, 0, 0);

    // start during RUN must not change the target
    do_start(2);
    do_start(7);
    push(32'sd1, 32'sd1);
    push(32'sd2, 32'sd2);
    wait_done();
    check("ignored_start_done", done, 1);
    check_stats("ignored_start", 2, 2, 0, 0, 3);

    // Randomized run of 1000 pairs against the integer reference
    ref_err = 0;
    ref_sq = 0;
    ref_abs = 0;
    ref_exact = 0;
    do_start(1000);
    for (int i = 0; i < 1000; i++) begin
      a12 = 12'($urandom);
      b12 = 12'($urandom);
      pp = int'(a12) * int'(b12);
      pa = mul_ex_12bit_model(int'(a12), int'(b12));
      e = longint'(pa) - longint'(pp);
      ref_err += e;
      ref_sq += e * e;
      ref_abs += (pp < 0) ? -longint'(pp) : longint'(pp);
      if (e == 0) ref_exact++;
      if ($urandom_range(0, 3) == 0) step();
      push(pa, pp);
    end
    wait_done();
    check_stats("random", 1000, ref_exact, ref_err, ref_sq, ref_abs);

    // DONE holds its values while the inputs wiggle
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'($urandom);
      appr = $urandom;
      precise = $urandom;
      step();
    end
    in_valid = 1'b0;
    check("hold_done", done, 1);
    check("hold_in_ready", in_ready, 0);
    check_stats("hold", 1000, ref_exact, ref_err, ref_sq, ref_abs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
